// File: rtl/mux_onehot_reg.sv
// mux_onehot_reg: registered N-way mux with a one-hot manual select, a rotating scan mode and a sticky illegal-select flag.
module mux_onehot_reg #(
  parameter int N = 3,
  parameter int W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*W-1:0]       d,
  input  logic [N-1:0]         s,
  input  logic                 mode,
  input  logic                 in_valid,
  input  logic                 err_clr,
  output logic [W-1:0]         o,
  output logic                 o_valid,
  output logic [$clog2(N)-1:0] ch,
  output logic                 err
);
  localparam int CW = $clog2(N);
  logic [CW-1:0] idx, idx_nxt, man_ch;
  logic [W-1:0] man_data, scan_data;
  logic legal;
  always_comb begin
    man_data = '0;
    man_ch = '0;
    scan_data = '0;
    for (int k = 0; k < N; k++) begin
      if (s[k]) begin
        man_data = d[k*W +: W];
        man_ch = CW'(k);
      end
      if (idx == CW'(k)) scan_data = d[k*W +: W];
    end
    legal = (s != '0) && ((s & (s - N'(1))) == '0);
    idx_nxt = (idx == CW'(N-1)) ? '0 : idx + CW'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o <= '0;
      o_valid <= 1'b0;
      ch <= '0;
      err <= 1'b0;
      idx <= '0;
    end else begin
      o_valid <= in_valid & (mode | legal);
      err <= (in_valid & ~mode & ~legal) | (err & ~err_clr);
      if (in_valid & mode) begin
        o <= scan_data;
        ch <= idx;
      end else if (in_valid & legal) begin
        o <= man_data;
        ch <= man_ch;
      end
      idx <= ~mode ? '0 : in_valid ? idx_nxt : idx;
    end
  end
endmodule

// File: tb/tb_mux_onehot_reg.sv
// tb_mux_onehot_reg: directed plus random checks of mux_onehot_reg (N=3, W=4) against a scoreboard fed by a behavioural model.
module tb_mux_onehot_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] d = '0;
  logic [2:0] s = '0;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic err_clr = 1'b0;
  logic [3:0] o;
  logic o_valid;
  logic [1:0] ch;
  logic err;
  int total = 0;
  int bad = 0;
  typedef struct packed {
    logic [3:0] o;
    logic [1:0] ch;
    logic v;
    logic err;
  } exp_t;
  exp_t q[$];
  logic [3:0] m_o;
  logic [1:0] m_ch, m_idx;
  logic m_err;

  mux_onehot_reg #(.N(3), .W(4)) dut (
    .clk(clk), .rst(rst), .d(d), .s(s), .mode(mode), .in_valid(in_valid),
    .err_clr(err_clr), .o(o), .o_valid(o_valid), .ch(ch), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".o"}, 8'(o), 8'(e.o));
    chk({tag, ".ch"}, 8'(ch), 8'(e.ch));
    chk({tag, ".o_valid"}, 8'(o_valid), 8'(e.v));
    chk({tag, ".err"}, 8'(err), 8'(e.err));
  endtask

  task automatic model_reset();
    m_o = '0;
    m_ch = '0;
    m_idx = '0;
    m_err = 1'b0;
  endtask

  task automatic cyc(input string tag, input logic [11:0] dd, input logic [2:0] ss,
                     input logic m, input logic iv, input logic ec);
    exp_t e;
    logic nv, set;
    d = dd;
    s = ss;
    mode = m;
    in_valid = iv;
    err_clr = ec;
    nv = 1'b0;
    set = 1'b0;
    if (iv) begin
      if (m) begin
        m_o = dd[m_idx*4 +: 4];
        m_ch = m_idx;
        nv = 1'b1;
        m_idx = (m_idx == 2'd2) ? 2'd0 : m_idx + 2'd1;
      end else begin
        case (ss)
          3'b001: begin m_o = dd[3:0]; m_ch = 2'd0; nv = 1'b1; end
          3'b010: begin m_o = dd[7:4]; m_ch = 2'd1; nv = 1'b1; end
          3'b100: begin m_o = dd[11:8]; m_ch = 2'd2; nv = 1'b1; end
          default: set = 1'b1;
        endcase
      end
    end
    if (!m) m_idx = 2'd0;
    m_err = set | (m_err & ~ec);
    q.push_back('{o: m_o, ch: m_ch, v: nv, err: m_err});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk_out(tag, e);
  endtask

  initial begin
    model_reset();
    #12;
    chk_out("reset", '{o: 4'h0, ch: 2'd0, v: 1'b0, err: 1'b0});
    rst = 1'b0;
    cyc("man_ch1", 12'hCBA, 3'b010, 1'b0, 1'b1, 1'b0);
    chk("man_ch1_direct", 8'(o), 8'hB);
    cyc("illegal_011", 12'hCBA, 3'b011, 1'b0, 1'b1, 1'b0);
    chk("illegal_err_direct", 8'(err), 8'h1);
    for (int i = 0; i < 5; i++) cyc("err_hold", 12'hCBA, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc("clr_vs_set", 12'hCBA, 3'b000, 1'b0, 1'b1, 1'b1);
    chk("set_wins_direct", 8'(err), 8'h1);
    cyc("clr", 12'hCBA, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("clr_direct", 8'(err), 8'h0);
    cyc("man_ch0", 12'h5E3, 3'b001, 1'b0, 1'b1, 1'b0);
    cyc("man_ch2", 12'h5E3, 3'b100, 1'b0, 1'b1, 1'b0);
    cyc("illegal_111", 12'h5E3, 3'b111, 1'b0, 1'b1, 1'b0);
    cyc("clr2", 12'h5E3, 3'b001, 1'b0, 1'b0, 1'b1);
    cyc("scan0", 12'hCBA, 3'b011, 1'b1, 1'b1, 1'b0);
    chk("scan0_ch_direct", 8'(ch), 8'h0);
    cyc("scan1", 12'hCBA, 3'b000, 1'b1, 1'b1, 1'b0);
    cyc("scan_idle", 12'hCBA, 3'b111, 1'b1, 1'b0, 1'b0);
    cyc("scan2", 12'hCBA, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("scan2_ch_direct", 8'(ch), 8'h2);
    cyc("scan_wrap", 12'hCBA, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("scan_wrap_o_direct", 8'(o), 8'hA);
    cyc("scan_to2", 12'hCBA, 3'b000, 1'b1, 1'b1, 1'b0);
    cyc("mode0_gap", 12'hCBA, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc("reentry", 12'hCBA, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("reentry_ch_direct", 8'(ch), 8'h0);
    cyc("pre_rst_illegal", 12'hCBA, 3'b000, 1'b0, 1'b1, 1'b0);
    cyc("pre_rst_scan0", 12'hCBA, 3'b000, 1'b1, 1'b1, 1'b0);
    cyc("pre_rst_scan1", 12'hCBA, 3'b000, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_out("async_rst", '{o: 4'h0, ch: 2'd0, v: 1'b0, err: 1'b0});
    #1;
    rst = 1'b0;
    cyc("post_rst_scan", 12'hCBA, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("post_rst_ch_direct", 8'(ch), 8'h0);
    for (int i = 0; i < 40; i++)
      cyc("rand", 12'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_onehot_reg.md
MUX_ONEHOT_REG -- requirements
Module: mux_onehot_reg

Interface
REQ-001 The block SHALL have parameter N, default 3: number of input channels; legal range N >= 2.
REQ-002 The block SHALL have parameter W, default 1: width in bits of each channel.
REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have input rst, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have input d, N*W bits: channel k occupies bits [k*W +: W].
REQ-006 The block SHALL have input s, N bits: one-hot channel select; bit k selects channel k.
REQ-007 The block SHALL have input mode, 1 bit: 0 = manual (select from s), 1 = scan (internal rotating index).
REQ-008 The block SHALL have input in_valid, 1 bit: sample request for the current cycle.
REQ-009 The block SHALL have input err_clr, 1 bit: clears the sticky error flag.
REQ-010 The block SHALL have output o, W bits, registered: selected channel data.
REQ-011 The block SHALL have output o_valid, 1 bit, registered: o was updated on the last edge.
REQ-012 The block SHALL have output ch, clog2(N) bits, registered: index of the channel now on o.
REQ-013 The block SHALL have output err, 1 bit, registered: sticky illegal-select flag.

Function
REQ-014 Latency SHALL be one clock: inputs sampled at edge t appear on o, ch and o_valid after edge t.
REQ-015 In manual mode, with in_valid=1 and s one-hot with bit k set, the block SHALL load o=d[k], ch=k and o_valid=1.
REQ-016 In manual mode, with in_valid=1 and s zero or with more than one bit set, the block SHALL hold o and ch, drive o_valid=0 and set err=1.
REQ-017 With in_valid=0, in either mode, the block SHALL hold o, ch and the scan index, drive o_valid=0 and leave err unchanged.
REQ-018 In scan mode the block SHALL ignore s; each in_valid=1 cycle SHALL load o=d[idx], ch=idx and o_valid=1, then advance idx.
REQ-019 The scan index SHALL wrap from N-1 to 0; no other value outside 0..N-1 SHALL ever be held.
REQ-020 While mode=0 the scan index SHALL be forced to 0, so every entry into scan mode starts at channel 0.
REQ-021 A mode change SHALL take effect in the same cycle it is sampled; no pipeline bubble.
REQ-022 err SHALL stay 1 until a cycle with err_clr=1.
REQ-023 If err_clr=1 and a new illegal select occur in the same cycle, err SHALL remain 1 (set wins).
REQ-024 Illegal select in scan mode SHALL NOT be possible; s is don't-care there and SHALL NOT affect err.
REQ-025 The block SHALL produce no combinational path from any input to any output.

Reset
REQ-026 While rst=1, asynchronously and independent of clk: o=0, o_valid=0, ch=0, err=0, scan index=0.
REQ-027 Reset asserted mid-scan SHALL discard the scan position; the first scan sample after release SHALL be channel 0.
REQ-028 On the first rising edge after rst deasserts, the block SHALL operate normally per REQ-014..REQ-025.

Verification (N=3, W=4)
REQ-029 Manual: d={C,B,A} (ch2..ch0), s=3'b010, in_valid=1 -> next cycle o=0xB, ch=1, o_valid=1, err=0.
REQ-030 Illegal select: o=0xB held; s=3'b011, in_valid=1 -> o=0xB, ch=1, o_valid=0, err=1; err stays 1 with s=3'b000 and in_valid=0 for 5 cycles.
REQ-031 Clear vs set: err=1; err_clr=1 with s=3'b000, in_valid=1 -> err=1; next cycle err_clr=1 with in_valid=0 -> err=0.
REQ-032 Scan wrap: mode=1, in_valid=1 for 4 cycles -> ch sequence 0,1,2,0, o sequence 0xA,0xB,0xC,0xA, o_valid=1 each cycle; one in_valid=0 cycle in the middle holds o, ch and idx with o_valid=0.
REQ-033 Mode re-entry: scan stopped at idx=2; mode=0 for 1 cycle, then mode=1, in_valid=1 -> ch=0.
REQ-034 Async reset: rst pulsed between clock edges mid-scan -> o=0, o_valid=0, ch=0, err=0 immediately; next scan sample gives ch=0.
